// File: rtl/aes_uart_rx_frontend.sv
// aes_uart_rx_frontend
//   Receive front end of the AES/UART link. Deserialises 8N1 bytes from rx,
//   packs 16 of them into a 128-bit ciphertext block (byte 0 in [127:120]),
//   hands the block to an external AES-CTR core with a one-cycle enable and
//   latches the core's result as recovered plaintext.
// Ports
//   clk, reset          system clock, synchronous active-high reset
//   rx                  UART serial input (idle high, asynchronous)
//   aes_enable          1-cycle pulse, aes_block valid
//   aes_block           block handed to the AES core
//   aes_valid           AES result strobe, aes_result sampled with it
//   aes_result          AES core output
//   outputplaintext     latched AES result
//   plain_valid         1-cycle pulse, outputplaintext updated
//   busy                block handed off, result pending
//   frame_err           1-cycle pulse, stop bit sampled low
//   timeout_err         1-cycle pulse, partial block discarded on idle
//   overrun_err         1-cycle pulse, block completed while busy and dropped
module aes_uart_rx_frontend #(
  parameter int CLK_FREQ     = 50000000,
  parameter int BAUD_RATE    = 115200,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         rx,
  output logic         aes_enable,
  output logic [127:0] aes_block,
  input  logic         aes_valid,
  input  logic [127:0] aes_result,
  output logic [127:0] outputplaintext,
  output logic         plain_valid,
  output logic         busy,
  output logic         frame_err,
  output logic         timeout_err,
  output logic         overrun_err
);

  localparam int BAUD_DIV = CLK_FREQ / BAUD_RATE;
  localparam int HALF     = BAUD_DIV / 2;
  localparam int LIMIT    = TIMEOUT_BITS * BAUD_DIV;
  localparam int BW       = $clog2(BAUD_DIV + 1);
  localparam int IW       = $clog2(LIMIT + 1);

  typedef enum logic [2:0] {
    RX_WAIT_HIGH, RX_IDLE, RX_START, RX_DATA, RX_STOP
  } rx_state_t;
  typedef enum logic {C_IDLE, C_WAIT} c_state_t;

  rx_state_t      rx_state;
  c_state_t       c_state;
  logic           rx_m, rx_s;
  logic [BW-1:0]  bcnt;
  logic [2:0]     bit_idx;
  logic [7:0]     shreg;
  logic           byte_vld;
  logic [7:0]     byte_data;
  logic [127:0]   blk_buf;
  logic [4:0]     count;
  logic [IW-1:0]  idle;
  logic [6:0]     byte_lsb;

  // Byte n lands at bit 127-8n downwards, i.e. lsb = (15-n)*8.
  assign byte_lsb = {~count[3:0], 3'b000};

  // Synchroniser + receiver FSM.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_m      <= 1'b1;
      rx_s      <= 1'b1;
      rx_state  <= RX_WAIT_HIGH;
      bcnt      <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      byte_vld  <= 1'b0;
      byte_data <= '0;
      frame_err <= 1'b0;
    end else begin
      rx_m      <= rx;
      rx_s      <= rx_m;
      byte_vld  <= 1'b0;
      frame_err <= 1'b0;
      case (rx_state)
        // The synchroniser resets to 1, so its first two samples prove
        // nothing about the line; demand three consecutive highs.
        RX_WAIT_HIGH: begin
          if (rx_s) begin
            if (bcnt == BW'(2)) begin
              rx_state <= RX_IDLE;
              bcnt     <= '0;
            end else bcnt <= bcnt + BW'(1);
          end else bcnt <= '0;
        end
        RX_IDLE: begin
          if (!rx_s) begin
            rx_state <= RX_START;
            bcnt     <= '0;
          end
        end
        RX_START: begin
          if (bcnt == BW'(HALF - 1)) begin
            bcnt     <= '0;
            bit_idx  <= '0;
            rx_state <= rx_s ? RX_IDLE : RX_DATA;
          end else bcnt <= bcnt + BW'(1);
        end
        RX_DATA: begin
          if (bcnt == BW'(BAUD_DIV - 1)) begin
            bcnt    <= '0;
            shreg   <= {rx_s, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) rx_state <= RX_STOP;
          end else bcnt <= bcnt + BW'(1);
        end
        RX_STOP: begin
          if (bcnt == BW'(BAUD_DIV - 1)) begin
            bcnt <= '0;
            if (rx_s) begin
              byte_vld  <= 1'b1;
              byte_data <= shreg;
              rx_state  <= RX_IDLE;
            end else begin
              frame_err <= 1'b1;
              rx_state  <= RX_WAIT_HIGH;
            end
          end else bcnt <= bcnt + BW'(1);
        end
        default: rx_state <= RX_WAIT_HIGH;
      endcase
    end
  end

  // Packing, idle timeout and AES hand-off FSM.
  always_ff @(posedge clk) begin
    if (reset) begin
      c_state         <= C_IDLE;
      blk_buf         <= '0;
      count           <= '0;
      idle            <= '0;
      aes_enable      <= 1'b0;
      aes_block       <= '0;
      outputplaintext <= '0;
      plain_valid     <= 1'b0;
      busy            <= 1'b0;
      timeout_err     <= 1'b0;
      overrun_err     <= 1'b0;
    end else begin
      aes_enable  <= 1'b0;
      plain_valid <= 1'b0;
      timeout_err <= 1'b0;
      overrun_err <= 1'b0;

      if (c_state == C_WAIT && aes_valid) begin
        outputplaintext <= aes_result;
        plain_valid     <= 1'b1;
        busy            <= 1'b0;
        c_state         <= C_IDLE;
      end

      if (count == 5'd16) begin
        if (c_state == C_IDLE) begin
          aes_block  <= blk_buf;
          aes_enable <= 1'b1;
          busy       <= 1'b1;
          count      <= '0;
          c_state    <= C_WAIT;
        end else if (!aes_valid) begin
          overrun_err <= 1'b1;
          count       <= '0;
        end
        // Completion coinciding with aes_valid: keep count at 16 so the
        // block issues from C_IDLE on the following cycle.
      end else if (byte_vld) begin
        // An accepted byte always beats a timeout on the same cycle.
        blk_buf[byte_lsb +: 8] <= byte_data;
        count                  <= count + 5'd1;
        idle                   <= '0;
      end else if (count != 5'd0) begin
        if (idle == IW'(LIMIT - 1)) begin
          count       <= '0;
          idle        <= '0;
          timeout_err <= 1'b1;
        end else idle <= idle + IW'(1);
      end
    end
  end

endmodule
